// File: rtl/nios_nios2_gen2_0_cpu_div_cell.sv
// Iterative radix-2 restoring divider for div/divu.
// Ports: clk, reset, div_start/signed/dividend/divisor/kill in; div_busy/done/quotient/remainder/by_zero out.
module nios_nios2_gen2_0_cpu_div_cell #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              div_start,
  input  logic              div_signed,
  input  logic [DATA_W-1:0] div_dividend,
  input  logic [DATA_W-1:0] div_divisor,
  input  logic              div_kill,
  output logic              div_busy,
  output logic              div_done,
  output logic [DATA_W-1:0] div_quotient,
  output logic [DATA_W-1:0] div_remainder,
  output logic              div_by_zero
);

  localparam int CW = $clog2(DATA_W);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CALC,
    S_FIX,
    S_ZERO
  } state_t;

  state_t            st_q;
  logic              sgn_q;
  logic              sq_q;
  logic              sr_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [DATA_W-1:0] rem_q;
  logic [CW-1:0]     cnt_q;
  logic [DATA_W-1:0] quot_q;
  logic [DATA_W-1:0] remo_q;
  logic              dz_q;
  logic              done_q;

  logic [DATA_W:0]   rem_sh;
  logic [DATA_W:0]   trial;
  logic [DATA_W-1:0] rem_d;
  logic [DATA_W-1:0] q_d;
  logic [DATA_W-1:0] q_fix;
  logic [DATA_W-1:0] r_fix;
  logic [DATA_W-1:0] a_abs;
  logic [DATA_W-1:0] b_abs;

  // a_q doubles as the quotient shift register during CALC;
  // the last step's result is sign-fixed and committed directly
  // so the done cycle already shows the final values.
  always_comb begin
    rem_sh = {rem_q, a_q[DATA_W-1]};
    trial  = rem_sh - {1'b0, b_q};
    rem_d  = rem_sh[DATA_W-1:0];
    q_d    = {a_q[DATA_W-2:0], 1'b0};
    if (!trial[DATA_W]) begin
      rem_d = trial[DATA_W-1:0];
      q_d   = {a_q[DATA_W-2:0], 1'b1};
    end
    q_fix = sq_q ? -q_d : q_d;
    r_fix = sr_q ? -rem_d : rem_d;
    a_abs = (sgn_q && a_q[DATA_W-1]) ? -a_q : a_q;
    b_abs = (sgn_q && b_q[DATA_W-1]) ? -b_q : b_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q   <= S_IDLE;
      sgn_q  <= 1'b0;
      sq_q   <= 1'b0;
      sr_q   <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      rem_q  <= '0;
      cnt_q  <= '0;
      quot_q <= '0;
      remo_q <= '0;
      dz_q   <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (st_q)
        S_IDLE: begin
          if (div_start && !div_kill) begin
            sgn_q <= div_signed;
            a_q   <= div_dividend;
            b_q   <= div_divisor;
            if (div_divisor == '0) begin
              quot_q <= '1;
              remo_q <= div_dividend;
              dz_q   <= 1'b1;
              done_q <= 1'b1;
              st_q   <= S_ZERO;
            end else begin
              st_q <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          if (div_kill) begin
            st_q <= S_IDLE;
          end else begin
            a_q   <= a_abs;
            b_q   <= b_abs;
            sq_q  <= sgn_q & (a_q[DATA_W-1] ^ b_q[DATA_W-1]);
            sr_q  <= sgn_q & a_q[DATA_W-1];
            rem_q <= '0;
            cnt_q <= '0;
            st_q  <= S_CALC;
          end
        end
        S_CALC: begin
          if (div_kill) begin
            st_q <= S_IDLE;
          end else begin
            a_q   <= q_d;
            rem_q <= rem_d;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CW'(DATA_W - 1)) begin
              quot_q <= q_fix;
              remo_q <= r_fix;
              dz_q   <= 1'b0;
              done_q <= 1'b1;
              st_q   <= S_FIX;
            end
          end
        end
        S_FIX:   st_q <= S_IDLE;
        S_ZERO:  st_q <= S_IDLE;
        default: st_q <= S_IDLE;
      endcase
    end
  end

  assign div_busy      = (st_q != S_IDLE);
  assign div_done      = done_q;
  assign div_quotient  = quot_q;
  assign div_remainder = remo_q;
  assign div_by_zero   = dz_q;

endmodule

// File: tb/tb_nios_nios2_gen2_0_cpu_div_cell.sv
// Self-checking bench for the iterative divider cell.
// Random and directed ops checked against an arithmetic reference.
module tb_nios_nios2_gen2_0_cpu_div_cell;

  logic        clk = 1'b0;
  logic        reset;
  logic        div_start;
  logic        div_signed;
  logic [31:0] div_dividend;
  logic [31:0] div_divisor;
  logic        div_kill;
  logic        div_busy;
  logic        div_done;
  logic [31:0] div_quotient;
  logic [31:0] div_remainder;
  logic        div_by_zero;

  int vec = 0;
  int err = 0;

  logic [31:0] pq, pr;
  logic        pdz;

  always #5 clk = ~clk;

  nios_nios2_gen2_0_cpu_div_cell #(.DATA_W(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .div_start    (div_start),
    .div_signed   (div_signed),
    .div_dividend (div_dividend),
    .div_divisor  (div_divisor),
    .div_kill     (div_kill),
    .div_busy     (div_busy),
    .div_done     (div_done),
    .div_quotient (div_quotient),
    .div_remainder(div_remainder),
    .div_by_zero  (div_by_zero)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    vec++;
    assert (got === exp) else begin
      err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic ref_div(input logic s, input logic [31:0] a,
                         input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r,
                         output logic dz);
    longint sa, sb;
    if (b == 0) begin
      q = '1; r = a; dz = 1'b1;
    end else begin
      dz = 1'b0;
      if (s) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q  = 32'(sa / sb);
        r  = 32'(sa % sb);
      end else begin
        q = a / b;
        r = a % b;
      end
    end
  endtask

  // Called at a falling edge; leaves the bench at the falling edge of
  // the cycle after done, so consecutive calls run back-to-back.
  task automatic run_op(input logic s, input logic [31:0] a,
                        input logic [31:0] b);
    logic [31:0] eq, er;
    logic        edz;
    int          lat, elat;
    ref_div(s, a, b, eq, er, edz);
    elat = (b == 0) ? 1 : 34;
    div_start    = 1'b1;
    div_signed   = s;
    div_dividend = a;
    div_divisor  = b;
    @(posedge clk);
    #1;
    div_start    = 1'b0;
    div_signed   = 1'($urandom_range(0, 1));
    div_dividend = $urandom;
    div_divisor  = $urandom;
    lat = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      chk("busy_inflight", 32'(div_busy), 32'd1);
      if (div_done === 1'b1) begin
        lat = c;
        div_start = 1'b0;
        break;
      end
      div_start = 1'($urandom_range(0, 1));
    end
    chk("latency", 32'(lat), 32'(elat));
    chk("quotient", div_quotient, eq);
    chk("remainder", div_remainder, er);
    chk("by_zero", 32'(div_by_zero), 32'(edz));
    @(negedge clk);
    chk("busy_after", 32'(div_busy), 32'd0);
    chk("done_pulse", 32'(div_done), 32'd0);
    chk("q_hold", div_quotient, eq);
    pq = eq; pr = er; pdz = edz;
  endtask

  initial begin
    logic        s;
    logic [31:0] a, b;
    reset = 1'b1;
    div_start = 1'b0; div_signed = 1'b0; div_kill = 1'b0;
    div_dividend = '0; div_divisor = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(div_busy), 32'd0);
    chk("rst_done", 32'(div_done), 32'd0);
    chk("rst_q", div_quotient, 32'd0);
    chk("rst_r", div_remainder, 32'd0);
    chk("rst_dz", 32'(div_by_zero), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    run_op(1'b0, 32'd100, 32'd7);
    run_op(1'b1, 32'hFFFF_FFF9, 32'd2);
    run_op(1'b0, 32'hFFFF_FFF9, 32'd2);
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(1'b0, 32'd5, 32'd0);
    run_op(1'b1, 32'hFFFF_FFF7, 32'd0);
    run_op(1'b1, 32'd7, 32'hFFFF_FFFE);
    run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op(1'b1, 32'h8000_0000, 32'd1);

    // kill mid-op: no done, prior result held, then a clean restart
    div_start = 1'b1; div_signed = 1'b0;
    div_dividend = 32'd100; div_divisor = 32'd7;
    @(posedge clk);
    #1;
    div_start = 1'b0;
    repeat (10) @(negedge clk);
    div_kill = 1'b1;
    @(negedge clk);
    div_kill = 1'b0;
    chk("kill_busy", 32'(div_busy), 32'd0);
    chk("kill_done", 32'(div_done), 32'd0);
    chk("kill_q", div_quotient, pq);
    chk("kill_r", div_remainder, pr);
    chk("kill_dz", 32'(div_by_zero), 32'(pdz));
    run_op(1'b0, 32'd1000, 32'd33);

    // kill together with start in IDLE: nothing accepted
    div_start = 1'b1; div_kill = 1'b1;
    div_dividend = 32'd9; div_divisor = 32'd0;
    @(negedge clk);
    div_start = 1'b0; div_kill = 1'b0;
    chk("killstart_busy", 32'(div_busy), 32'd0);
    chk("killstart_done", 32'(div_done), 32'd0);
    chk("killstart_q", div_quotient, pq);
    @(negedge clk);
    chk("killstart_done2", 32'(div_done), 32'd0);

    // reset mid-op: all outputs cleared, no done afterwards
    div_start = 1'b1; div_signed = 1'b1;
    div_dividend = 32'hFFFF_FF00; div_divisor = 32'd3;
    @(posedge clk);
    #1;
    div_start = 1'b0;
    repeat (20) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mrst_busy", 32'(div_busy), 32'd0);
    chk("mrst_done", 32'(div_done), 32'd0);
    chk("mrst_q", div_quotient, 32'd0);
    chk("mrst_r", div_remainder, 32'd0);
    chk("mrst_dz", 32'(div_by_zero), 32'd0);
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      chk("mrst_quiet", {30'd0, div_busy, div_done}, 32'd0);
    end

    for (int i = 0; i < 30; i++) begin
      s = 1'($urandom_range(0, 1));
      a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1, 2, 3: b = 32'($urandom_range(1, 20));
        4:       b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      run_op(s, a, b);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
